mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the icache and dcache of NCPU cores.
- Picks one requester at a time (round-robin across cores, dcache before icache within a core), holds the grant across multi-word block transfers, and returns RAM completion as per-requester wait/load.
- Sits between the caches and the RAM model, below the cache FSMs.

Parameters:
- NCPU, 2, number of cores (requesters = 2*NCPU).
- MAX_BURST, 4, max RAM words completed under one grant before forced release (fairness).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- iREN  in  NCPU  icache read request per core.
- iaddr  in  NCPU x 32  icache word address.
- iwait  out  NCPU  1 = icache must hold request; 0 = iload valid this cycle.
- iload  out  NCPU x 32  read data to icache.
- dREN  in  NCPU  dcache read request.
- dWEN  in  NCPU  dcache write request.
- daddr  in  NCPU x 32  dcache word address.
- dstore  in  NCPU x 32  dcache write data.
- dwait  out  NCPU  1 = dcache must hold request.
- dload  out  NCPU x 32  read data to dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS (word done this cycle), ERROR.

Behaviour:
- Reset (RST high, async): state IDLE, rr_ptr = 0, burst_cnt = 0, grant invalid.
  - Outputs forced: iwait = dwait = all 1, ramREN = ramWEN = 0, ramaddr = ramstore = 0, iload = dload = 0.
  - Reset mid-transfer abandons it. No RAM enable is asserted in the cycle after reset deasserts.
- Requester index r = 2*cpu + {0: dcache, 1: icache}. A requester is active if it is dcache with dREN|dWEN, or icache with iREN.
- Selection (combinational, used only in IDLE):
  - Scan cores starting at rr_ptr, wrapping modulo NCPU.
  - First core with any active requester wins. Its dcache beats its icache.
- FSM states: IDLE, GRANT, RELEASE.
  - IDLE: if any requester is active, register grant = selected, burst_cnt = 0, go GRANT (1-cycle arbitration latency). Otherwise stay.
  - GRANT: RAM signals are combinationally muxed from the granted requester.
    - dcache with dWEN: ramWEN = 1, ramstore = dstore. This applies even if dREN is also high; dWEN wins.
    - dcache read, or icache: ramREN = 1.
    - ramaddr = granted address, live each cycle so the cache can step addr/addr+4 under one grant.
  - Word completion: when ramstate == ACCESS, the granted wait = 0 for that cycle only, load = ramload, and burst_cnt increments.
  - Leave GRANT for RELEASE when any of these holds:
    - the granted request drops;
    - burst_cnt reaches MAX_BURST on an ACCESS cycle;
    - ramstate == ERROR, which also completes the word with wait = 0 and load = 0.
  - RELEASE: RAM enables 0, all waits 1. rr_ptr = (granted cpu + 1) mod NCPU. Go IDLE. This gives 1 turnaround cycle.
- Every non-granted requester sees wait = 1 and load = 0 every cycle.
- A requester must hold its request and address stable until wait = 0. Requests that appear or vanish while not granted are legal.
- Forced release at MAX_BURST with the request still high: that requester re-enters arbitration behind the others. rr_ptr has already advanced past its core.
- ramstate BUSY/FREE in GRANT: hold, waits stay 1. The arbiter has no timeout.
- Single requester active: it is re-granted after IDLE with 2 dead cycles between grants (RELEASE, IDLE).

Decomposition:
- Add to cpu_types_pkg: ramstate_t (if absent), arb_state_t {IDLE, GRANT, RELEASE}, REQ_W = $clog2(2*NCPU).
- Sub-module rr_picker: pure combinational round-robin priority encoder. Inputs are the active vector and rr_ptr; outputs are grant index and valid. It is reusable for bus snoop arbitration later.

Test Plan:
- Single dcache read core0, daddr=0x100, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1 from cycle after request; dwait[0]=0 for exactly one cycle with dload[0]=0xDEADBEEF.
- Two-word dcache writeback core0 (0x200 then 0x204, dstore 0x11/0x22) -> one grant, two ACCESS completions, ramaddr follows cache, no RELEASE between words.
- Core0 iREN and dREN together -> dcache granted first. After its request drops: RELEASE, IDLE, then icache granted.
- Core0 and core1 dREN held continuously, MAX_BURST=4 -> grants alternate core0, core1, core0. No grant exceeds 4 ACCESS completions.
- Reset asserted mid GRANT (after first ACCESS) -> all waits 1 and ramREN/ramWEN 0 immediately. After release, IDLE with rr_ptr=0.
- ramstate=ERROR during core1 icache read -> iwait[1]=0 for one cycle with iload[1]=0, then RELEASE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-to-RAM arbiter.
// RAM handshake states, arbiter FSM states and sizing helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int NCPU_DEF      = 2;
    localparam int MAX_BURST_DEF = 4;
    localparam int REQ_W         = $clog2(2 * NCPU_DEF);

    // Requester index width for a given core count
    function automatic int req_w(input int ncpu);
        return (2 * ncpu > 1) ? $clog2(2 * ncpu) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder over core pairs.
// Ports: i_active (2 bits/core, dcache=even), i_ptr start core, o_idx, o_valid.
module rr_picker #(
    parameter int NCPU  = 2,
    parameter int REQ_W = 2,
    parameter int CPU_W = 1
) (
    input  logic [2*NCPU-1:0] i_active,
    input  logic [CPU_W-1:0]  i_ptr,
    output logic [REQ_W-1:0]  o_idx,
    output logic              o_valid
);

    int w_c;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_c     = 0;
        for (int k = 0; k < NCPU; k++) begin
            w_c = (int'(i_ptr) + k) % NCPU;
            if (!o_valid) begin
                // dcache of a core outranks its icache
                if (i_active[2*w_c]) begin
                    o_idx   = REQ_W'(2 * w_c);
                    o_valid = 1'b1;
                end else if (i_active[2*w_c+1]) begin
                    o_idx   = REQ_W'(2 * w_c + 1);
                    o_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port among NCPU icache/dcache pairs.
// Ports: CLK/RST, per-core i*/d* cache side, ram* RAM side, ramstate status.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NCPU      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NCPU-1:0]       iREN,
    input  logic [NCPU-1:0][31:0] iaddr,
    output logic [NCPU-1:0]       iwait,
    output logic [NCPU-1:0][31:0] iload,
    input  logic [NCPU-1:0]       dREN,
    input  logic [NCPU-1:0]       dWEN,
    input  logic [NCPU-1:0][31:0] daddr,
    input  logic [NCPU-1:0][31:0] dstore,
    output logic [NCPU-1:0]       dwait,
    output logic [NCPU-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);

    localparam int RW    = req_w(NCPU);
    localparam int CPU_W = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int BCW   = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    logic [RW-1:0]    r_grant;
    logic [CPU_W-1:0] r_rr_ptr;
    logic [BCW-1:0]   r_burst_cnt;

    logic [2*NCPU-1:0] w_active;
    logic [RW-1:0]     w_pick;
    logic              w_pick_vld;
    logic [CPU_W-1:0]  w_gcpu;
    logic              w_gicache;
    logic              w_greq;
    logic              w_done;
    logic [BCW-1:0]    w_burst_nxt;

    always_comb begin
        w_active = '0;
        for (int c = 0; c < NCPU; c++) begin
            w_active[2*c]   = dREN[c] | dWEN[c];
            w_active[2*c+1] = iREN[c];
        end
    end

    rr_picker #(
        .NCPU  (NCPU),
        .REQ_W (RW),
        .CPU_W (CPU_W)
    ) u_picker (
        .i_active (w_active),
        .i_ptr    (r_rr_ptr),
        .o_idx    (w_pick),
        .o_valid  (w_pick_vld)
    );

    assign w_gcpu      = CPU_W'(r_grant >> 1);
    assign w_gicache   = r_grant[0];
    assign w_greq      = w_active[r_grant];
    assign w_burst_nxt = r_burst_cnt + BCW'(1);
    assign w_done      = (r_state == GRANT) && w_greq &&
                         (ramstate == ACCESS || ramstate == ERROR);

    // RAM side and cache responses follow the grant combinationally
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (r_state == GRANT) begin
            if (w_gicache) begin
                ramREN  = iREN[w_gcpu];
                ramaddr = iaddr[w_gcpu];
                if (w_done) begin
                    iwait[w_gcpu] = 1'b0;
                    iload[w_gcpu] = (ramstate == ACCESS) ? ramload : '0;
                end
            end else begin
                // a write takes precedence over a read on the same cycle
                ramWEN  = dWEN[w_gcpu];
                ramREN  = dREN[w_gcpu] & ~dWEN[w_gcpu];
                ramaddr = daddr[w_gcpu];
                if (dWEN[w_gcpu])
                    ramstore = dstore[w_gcpu];
                if (w_done) begin
                    dwait[w_gcpu] = 1'b0;
                    dload[w_gcpu] = (ramstate == ACCESS) ? ramload : '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_grant     <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_greq || ramstate == ERROR) begin
                        r_state <= RELEASE;
                    end else if (ramstate == ACCESS) begin
                        r_burst_cnt <= w_burst_nxt;
                        // fairness: drop the grant after a full burst
                        if (w_burst_nxt == BCW'(MAX_BURST))
                            r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_rr_ptr <= CPU_W'((int'(w_gcpu) + 1) % NCPU);
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (NCPU=2, MAX_BURST=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait;
    logic [1:0][31:0] iload, dload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    ramstate_t        ramstate;

    int n_checks = 0;
    int n_errors = 0;
    int cpu_exp;
    logic [31:0] pat;

    mem_arbiter #(.NCPU(2), .MAX_BURST(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    initial begin
        RST      = 1'b1;
        iREN     = '0;
        dREN     = '0;
        dWEN     = '0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;

        // reset state
        tick; #1;
        check("rst_iwait", 32'(iwait), 32'h3);
        check("rst_dwait", 32'(dwait), 32'h3);
        check("rst_ren", 32'(ramREN), 32'h0);
        check("rst_wen", 32'(ramWEN), 32'h0);
        check("rst_addr", ramaddr, 32'h0);
        tick; RST = 1'b0; #1;
        check("rst_rel_ren", 32'(ramREN), 32'h0);

        // single dcache read, two BUSY then ACCESS
        tick;
        dREN = 2'b01; daddr[0] = 32'h100; ramstate = BUSY; #1;
        check("t1_idle_ren", 32'(ramREN), 32'h0);
        tick; #1;
        check("t1_ren", 32'(ramREN), 32'h1);
        check("t1_addr", ramaddr, 32'h100);
        check("t1_busy1", 32'(dwait), 32'h3);
        tick; #1;
        check("t1_busy2", 32'(dwait), 32'h3);
        tick; ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        check("t1_dwait", 32'(dwait), 32'h2);
        check("t1_dload", dload[0], 32'hDEADBEEF);
        check("t1_iwait", 32'(iwait), 32'h3);
        tick; dREN = 2'b00; ramstate = FREE; #1;
        check("t1_after", 32'(dwait), 32'h3);
        check("t1_after_ld", dload[0], 32'h0);
        tick; #1;
        check("t1_rel_ren", 32'(ramREN), 32'h0);
        tick;

        // two-word writeback under one grant
        dWEN = 2'b01; daddr[0] = 32'h200; dstore[0] = 32'h11;
        ramstate = BUSY; #1;
        check("t2_idle_wen", 32'(ramWEN), 32'h0);
        tick; ramstate = ACCESS; #1;
        check("t2_wen0", 32'(ramWEN), 32'h1);
        check("t2_ren0", 32'(ramREN), 32'h0);
        check("t2_addr0", ramaddr, 32'h200);
        check("t2_st0", ramstore, 32'h11);
        check("t2_wait0", 32'(dwait), 32'h2);
        tick; daddr[0] = 32'h204; dstore[0] = 32'h22; #1;
        check("t2_wen1", 32'(ramWEN), 32'h1);
        check("t2_addr1", ramaddr, 32'h204);
        check("t2_st1", ramstore, 32'h22);
        check("t2_wait1", 32'(dwait), 32'h2);
        tick; dWEN = 2'b00; ramstate = FREE; #1;
        check("t2_drop_wen", 32'(ramWEN), 32'h0);
        tick; tick;

        // dcache before icache on the same core
        dREN = 2'b01; iREN = 2'b01;
        daddr[0] = 32'h300; iaddr[0] = 32'h400;
        tick; #1;
        check("t3_daddr", ramaddr, 32'h300);
        check("t3_dren", 32'(ramREN), 32'h1);
        ramstate = ACCESS; ramload = 32'hA; #1;
        check("t3_dwait", 32'(dwait), 32'h2);
        check("t3_iwait", 32'(iwait), 32'h3);
        check("t3_dload", dload[0], 32'hA);
        check("t3_iload", iload[0], 32'h0);
        tick; dREN = 2'b00; ramstate = FREE; #1;
        tick; #1;
        check("t3_rel_ren", 32'(ramREN), 32'h0);
        check("t3_rel_iw", 32'(iwait), 32'h3);
        tick; #1;
        check("t3_idle_ren", 32'(ramREN), 32'h0);
        tick; #1;
        check("t3_iaddr", ramaddr, 32'h400);
        check("t3_iren", 32'(ramREN), 32'h1);
        ramstate = ACCESS; ramload = 32'hB; #1;
        check("t3_iwait2", 32'(iwait), 32'h2);
        check("t3_iload2", iload[0], 32'hB);
        tick; iREN = 2'b00; ramstate = FREE;
        tick; tick;

        // reset in the middle of a grant
        dREN = 2'b01; daddr[0] = 32'h500;
        tick; ramstate = ACCESS; ramload = 32'hC; #1;
        check("t5_first", 32'(dwait), 32'h2);
        tick; ramstate = BUSY; #1;
        check("t5_pre_ren", 32'(ramREN), 32'h1);
        RST = 1'b1; #1;
        check("t5_rst_dw", 32'(dwait), 32'h3);
        check("t5_rst_ren", 32'(ramREN), 32'h0);
        check("t5_rst_addr", ramaddr, 32'h0);
        dREN = 2'b00;
        tick; #1;
        check("t5_rst_iw", 32'(iwait), 32'h3);

        // release reset with both cores requesting continuously
        tick; RST = 1'b0;
        dREN = 2'b11; daddr[0] = 32'h600; daddr[1] = 32'h700;
        ramstate = ACCESS; #1;
        check("t4_post_rst", 32'(ramREN), 32'h0);
        for (int g = 0; g < 3; g++) begin
            cpu_exp = g % 2;
            for (int b = 0; b < 4; b++) begin
                tick;
                pat = 32'h5A000000 | 32'(g * 16 + b);
                ramload = pat; #1;
                check("t4_wait", 32'(dwait),
                      (cpu_exp == 0) ? 32'h2 : 32'h1);
                check("t4_addr", ramaddr,
                      (cpu_exp == 0) ? 32'h600 : 32'h700);
                check("t4_load", dload[cpu_exp], pat);
            end
            if (g < 2) begin
                tick; #1;
                check("t4_rel_wait", 32'(dwait), 32'h3);
                check("t4_rel_ren", 32'(ramREN), 32'h0);
                tick; #1;
                check("t4_idle_wait", 32'(dwait), 32'h3);
            end
        end
        tick; dREN = 2'b00; ramstate = FREE; #1;
        check("t4_end_wait", 32'(dwait), 32'h3);
        check("t4_end_ren", 32'(ramREN), 32'h0);
        tick;

        // ERROR completes a core1 icache read with zero data
        iREN = 2'b10; iaddr[1] = 32'h800;
        tick; ramstate = ERROR; ramload = 32'hFFFFFFFF; #1;
        check("t6_ren", 32'(ramREN), 32'h1);
        check("t6_addr", ramaddr, 32'h800);
        check("t6_iwait", 32'(iwait), 32'h1);
        check("t6_iload", iload[1], 32'h0);
        tick; ramstate = FREE; #1;
        check("t6_rel_iw", 32'(iwait), 32'h3);
        check("t6_rel_ren", 32'(ramREN), 32'h0);
        iREN = 2'b00;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
